// File: rtl/adam_stream_arb_if.sv
// ---------------------------------------------------------------------------
// adam_stream_arb_if
//   Point-to-point valid/ready stream carrying one data_t payload per beat.
//
//   Handshake: a beat transfers on a rising clock edge where valid && ready.
//   The source holds valid (and data) stable until that edge; ready may
//   change freely and may depend combinationally on valid.
//
//   Signals:
//     data   payload, driven by the master
//     valid  beat offered, driven by the master
//     ready  beat accepted, driven by the slave
//   Modports:
//     master  drives data/valid, samples ready
//     slave   samples data/valid, drives ready
// ---------------------------------------------------------------------------
interface adam_stream_arb_if #(
    parameter type data_t = logic
);
    data_t data;
    logic  valid;
    logic  ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/adam_stream_arb.sv
// ---------------------------------------------------------------------------
// adam_stream_arb
//   Round-robin arbiter sharing one downstream stream among NO_SLVS
//   upstream requesters. A grant lasts at most MAX_BURST handshakes, or
//   until the grantee drops valid. The data path is a pure mux selected by
//   the registered grant index; no payload storage.
//
//   Ports:
//     clk          sole clock, rising edge
//     rst          synchronous, active-low reset
//     slv[]        upstream requesters (data/valid in, ready out)
//     mst          shared downstream stream (data/valid out, ready in)
//     grant_valid  high while a grant is held (FSM in BUSY)
//     grant_idx    index of the current grantee
// ---------------------------------------------------------------------------
module adam_stream_arb #(
    parameter type data_t    = logic,
    parameter int  NO_SLVS   = 4,
    parameter int  MAX_BURST = 8,
    parameter int  IDX_WIDTH = $clog2(NO_SLVS)
) (
    input  logic                 clk,
    input  logic                 rst,
    adam_stream_arb_if.slave     slv [NO_SLVS],
    adam_stream_arb_if.master    mst,
    output logic                 grant_valid,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] g_q, g_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    data_t                slv_data [NO_SLVS];
    logic [NO_SLVS-1:0]   slv_valid;
    logic                 busy;
    logic                 beat;
    logic                 release_now;
    logic                 win_found;
    logic [IDX_WIDTH-1:0] win_idx;
    logic [IDX_WIDTH:0]   scan_sum;

    assign busy = (state_q == BUSY);

    for (genvar i = 0; i < NO_SLVS; i++) begin : g_slv
        assign slv_data[i]  = slv[i].data;
        assign slv_valid[i] = slv[i].valid;
        // Only the grantee sees downstream ready; everyone else is stalled.
        assign slv[i].ready = busy && (g_q == IDX_WIDTH'(i)) && mst.ready;
    end

    assign mst.valid   = busy && slv_valid[g_q];
    assign mst.data    = busy ? slv_data[g_q] : '0;
    assign grant_valid = busy;
    assign grant_idx   = g_q;

    assign beat        = busy && slv_valid[g_q] && mst.ready;
    assign release_now = (beat && (cnt_q == CNT_W'(MAX_BURST - 1))) ||
                         !slv_valid[g_q];

    // Scan from g+1 up to g itself. Iterating offsets from the far end down
    // lets the nearest valid index be the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = g_q;
        scan_sum  = '0;
        for (int k = NO_SLVS; k >= 1; k--) begin
            scan_sum = {1'b0, g_q} + (IDX_WIDTH + 1)'(k);
            if (scan_sum >= (IDX_WIDTH + 1)'(NO_SLVS)) begin
                scan_sum = scan_sum - (IDX_WIDTH + 1)'(NO_SLVS);
            end
            if (slv_valid[scan_sum[IDX_WIDTH-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        if (!busy || release_now) begin
            cnt_d = '0;
            if (win_found) begin
                state_d = BUSY;
                g_d     = win_idx;
            end else begin
                state_d = IDLE;
            end
        end else if (beat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            g_q     <= IDX_WIDTH'(NO_SLVS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_adam_stream_arb.sv
module tb_adam_stream_arb;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Instance with MAX_BURST=4
    logic [7:0] d4 [4];
    logic       v4 [4];
    logic       r4 [4];
    logic       m4_ready;
    logic       m4_valid;
    logic [7:0] m4_data;
    logic       gv4;
    logic [1:0] gi4;

    // Instance with MAX_BURST=1
    logic [7:0] d1 [4];
    logic       v1 [4];
    logic       r1 [4];
    logic       m1_ready;
    logic       m1_valid;
    logic [7:0] m1_data;
    logic       gv1;
    logic [1:0] gi1;

    adam_stream_arb_if #(.data_t(logic [7:0])) s4 [4] ();
    adam_stream_arb_if #(.data_t(logic [7:0])) m4 ();
    adam_stream_arb_if #(.data_t(logic [7:0])) s1 [4] ();
    adam_stream_arb_if #(.data_t(logic [7:0])) m1 ();

    for (genvar i = 0; i < 4; i++) begin : g_conn
        assign s4[i].data  = d4[i];
        assign s4[i].valid = v4[i];
        assign r4[i]       = s4[i].ready;
        assign s1[i].data  = d1[i];
        assign s1[i].valid = v1[i];
        assign r1[i]       = s1[i].ready;
    end
    assign m4.ready = m4_ready;
    assign m4_valid = m4.valid;
    assign m4_data  = m4.data;
    assign m1.ready = m1_ready;
    assign m1_valid = m1.valid;
    assign m1_data  = m1.data;

    adam_stream_arb #(.data_t(logic [7:0]), .NO_SLVS(4), .MAX_BURST(4)) u_b4 (
        .clk(clk), .rst(rst), .slv(s4), .mst(m4),
        .grant_valid(gv4), .grant_idx(gi4)
    );

    adam_stream_arb #(.data_t(logic [7:0]), .NO_SLVS(4), .MAX_BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .slv(s1), .mst(m1),
        .grant_valid(gv1), .grant_idx(gi1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            d4[i] = '0; v4[i] = 1'b0;
            d1[i] = '0; v1[i] = 1'b0;
        end
        m4_ready = 1'b1;
        m1_ready = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++; if (gv4 !== 1'b0) begin bad++; $display("FAIL reset_gv got=%b exp=0", gv4); end
        total++; if (gi4 !== 2'd3) begin bad++; $display("FAIL reset_gi got=%0d exp=3", gi4); end
        total++; if (m4_valid !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%b exp=0", m4_valid); end
        total++; if (m4_data !== 8'h00) begin bad++; $display("FAIL reset_mdata got=%h exp=00", m4_data); end
        for (int i = 0; i < 4; i++) begin
            total++; if (r4[i] !== 1'b0) begin bad++; $display("FAIL reset_ready%0d got=%b exp=0", i, r4[i]); end
        end
        total++; if (gi1 !== 2'd3) begin bad++; $display("FAIL reset_gi_b1 got=%0d exp=3", gi1); end
    endtask

    task automatic test_single();
        logic [7:0] pay [3];
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        m4_ready = 1'b1;
        v4[2] = 1'b1;
        d4[2] = pay[0];
        #1;
        total++; if (gv4 !== 1'b0) begin bad++; $display("FAIL single_idle_gv got=%b exp=0", gv4); end
        total++; if (r4[2] !== 1'b0) begin bad++; $display("FAIL single_idle_ready got=%b exp=0", r4[2]); end
        tick();
        for (int b = 0; b < 3; b++) begin
            d4[2] = pay[b];
            #1;
            total++; if (gi4 !== 2'd2) begin bad++; $display("FAIL single_gi beat%0d got=%0d exp=2", b, gi4); end
            total++; if (gv4 !== 1'b1) begin bad++; $display("FAIL single_gv beat%0d got=%b exp=1", b, gv4); end
            total++; if (m4_valid !== 1'b1) begin bad++; $display("FAIL single_mvalid beat%0d got=%b exp=1", b, m4_valid); end
            total++; if (m4_data !== pay[b]) begin bad++; $display("FAIL single_mdata beat%0d got=%h exp=%h", b, m4_data, pay[b]); end
            total++; if (r4[2] !== 1'b1) begin bad++; $display("FAIL single_ready beat%0d got=%b exp=1", b, r4[2]); end
            tick();
        end
        v4[2] = 1'b0;
        #1;
        total++; if (m4_valid !== 1'b0) begin bad++; $display("FAIL single_drop_mvalid got=%b exp=0", m4_valid); end
        tick();
        total++; if (gv4 !== 1'b0) begin bad++; $display("FAIL single_release_gv got=%b exp=0", gv4); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        d4[0] = 8'h10; d4[1] = 8'h20;
        v4[0] = 1'b1; v4[1] = 1'b1;
        m4_ready = 1'b1;
        tick();
        for (int c = 0; c < 16; c++) begin
            exp_g = ((c / 4) % 2 == 0) ? 2'd0 : 2'd1;
            total++; if (gi4 !== exp_g) begin bad++; $display("FAIL contend_gi cyc%0d got=%0d exp=%0d", c, gi4, exp_g); end
            total++; if (gv4 !== 1'b1) begin bad++; $display("FAIL contend_gv cyc%0d got=%b exp=1", c, gv4); end
            total++; if (m4_data !== ((exp_g == 2'd0) ? 8'h10 : 8'h20)) begin bad++; $display("FAIL contend_mdata cyc%0d got=%h", c, m4_data); end
            if (c < 15) tick();
        end
        v4[0] = 1'b0; v4[1] = 1'b0;
        tick();
        total++; if (gv4 !== 1'b0) begin bad++; $display("FAIL contend_release_gv got=%b exp=0", gv4); end
    endtask

    task automatic test_backpressure();
        logic rdy;
        // Requester 3 waits so the burst end becomes visible as a switch.
        d4[2] = 8'h33; d4[3] = 8'h44;
        v4[2] = 1'b1; v4[3] = 1'b1;
        m4_ready = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            rdy = (k % 2 == 0);
            m4_ready = rdy;
            #1;
            total++; if (gi4 !== 2'd2) begin bad++; $display("FAIL bp_gi cyc%0d got=%0d exp=2", k, gi4); end
            total++; if (r4[2] !== rdy) begin bad++; $display("FAIL bp_ready2 cyc%0d got=%b exp=%b", k, r4[2], rdy); end
            total++; if (r4[3] !== 1'b0) begin bad++; $display("FAIL bp_ready3 cyc%0d got=%b exp=0", k, r4[3]); end
            total++; if (r4[0] !== 1'b0) begin bad++; $display("FAIL bp_ready0 cyc%0d got=%b exp=0", k, r4[0]); end
            tick();
        end
        total++; if (gi4 !== 2'd3) begin bad++; $display("FAIL bp_switch_gi got=%0d exp=3", gi4); end
        total++; if (m4_data !== 8'h44) begin bad++; $display("FAIL bp_switch_mdata got=%h exp=44", m4_data); end
        v4[2] = 1'b0; v4[3] = 1'b0;
        m4_ready = 1'b1;
        tick();
        total++; if (gv4 !== 1'b0) begin bad++; $display("FAIL bp_release_gv got=%b exp=0", gv4); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        v4[3] = 1'b1;
        d4[3] = 8'h40;
        m4_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_d = 8'h40 + 8'(k);
            d4[3] = exp_d;
            #1;
            total++; if (gi4 !== 2'd3) begin bad++; $display("FAIL b2b_gi beat%0d got=%0d exp=3", k, gi4); end
            total++; if (gv4 !== 1'b1) begin bad++; $display("FAIL b2b_gv beat%0d got=%b exp=1", k, gv4); end
            total++; if (m4_valid !== 1'b1) begin bad++; $display("FAIL b2b_mvalid beat%0d got=%b exp=1", k, m4_valid); end
            total++; if (m4_data !== exp_d) begin bad++; $display("FAIL b2b_mdata beat%0d got=%h exp=%h", k, m4_data, exp_d); end
            tick();
        end
        v4[3] = 1'b0;
        tick();
        total++; if (gv4 !== 1'b0) begin bad++; $display("FAIL b2b_release_gv got=%b exp=0", gv4); end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] exp_g;
        v4[1] = 1'b1;
        d4[1] = 8'h11;
        m4_ready = 1'b1;
        tick();
        total++; if (gi4 !== 2'd1) begin bad++; $display("FAIL rmid_gi got=%0d exp=1", gi4); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (m4_valid !== 1'b0) begin bad++; $display("FAIL rmid_mvalid got=%b exp=0", m4_valid); end
        total++; if (gv4 !== 1'b0) begin bad++; $display("FAIL rmid_gv got=%b exp=0", gv4); end
        total++; if (gi4 !== 2'd3) begin bad++; $display("FAIL rmid_gi_rst got=%0d exp=3", gi4); end
        for (int i = 0; i < 4; i++) begin
            total++; if (r4[i] !== 1'b0) begin bad++; $display("FAIL rmid_ready%0d got=%b exp=0", i, r4[i]); end
        end
        rst = 1'b1;
        v4[2] = 1'b1;
        d4[2] = 8'h22;
        tick();
        // A fresh count gives slv[1] a full 4-beat burst before slv[2].
        for (int c = 0; c < 5; c++) begin
            exp_g = (c < 4) ? 2'd1 : 2'd2;
            total++; if (gi4 !== exp_g) begin bad++; $display("FAIL rmid_fresh_gi cyc%0d got=%0d exp=%0d", c, gi4, exp_g); end
            tick();
        end
        v4[1] = 1'b0; v4[2] = 1'b0;
        tick();
        total++; if (gv4 !== 1'b0) begin bad++; $display("FAIL rmid_release_gv got=%b exp=0", gv4); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'd3; exp_seq[1] = 2'd0; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0;
        m1_ready = 1'b1;
        d1[3] = 8'h03;
        d1[0] = 8'h0F;
        v1[3] = 1'b1;
        tick();
        v1[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++; if (gi1 !== exp_seq[c]) begin bad++; $display("FAIL wrap_gi step%0d got=%0d exp=%0d", c, gi1, exp_seq[c]); end
            total++; if (gv1 !== 1'b1) begin bad++; $display("FAIL wrap_gv step%0d got=%b exp=1", c, gv1); end
            total++; if (m1_data !== ((exp_seq[c] == 2'd3) ? 8'h03 : 8'h0F)) begin bad++; $display("FAIL wrap_mdata step%0d got=%h", c, m1_data); end
            tick();
        end
        v1[0] = 1'b0; v1[3] = 1'b0;
        tick();
        total++; if (gv1 !== 1'b0) begin bad++; $display("FAIL wrap_release_gv got=%b exp=0", gv1); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
